// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame assembler.
//   state_t  : assembler FSM states
//   FRAME_W  : width of the assembled frame bus
//   *_LSB    : bit offsets of the key, block A and block B fields in the frame
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam int FRAME_W  = 256;
  localparam int KEY_LSB  = 0;
  localparam int BLKA_LSB = 96;
  localparam int BLKB_LSB = 160;

endpackage

// File: rtl/uart_frame_assembler.sv
// UART frame assembler: pulls bytes out of a non-FWFT rx FIFO and packs them
// little-end-first into a 256-bit frame (key [95:0], block A [159:96],
// block B [223:160], [255:224] always zero). The finished frame is held with
// frame_valid until frame_ready accepts it.
//
// Optional feature (macro UART_FRAME_TIMEOUT_EN): an inter-byte idle counter
// discards a partial frame after TIMEOUT_CYCLES and pulses timeout_err.
// Without the macro there is no counter and timeout_err is tied low.
//
// Ports:
//   clk_100MHz   in   system clock
//   reset_n      in   asynchronous active-low reset
//   rx_empty     in   rx FIFO empty flag
//   rx_data      in   rx FIFO read data, valid the cycle after rd_uart
//   rd_uart      out  rx FIFO read strobe, one cycle per byte
//   frame_data   out  assembled frame
//   frame_valid  out  frame_data complete and stable
//   frame_ready  in   downstream accept
//   busy         out  partial frame held
//   byte_cnt     out  bytes captured in current frame
//   timeout_err  out  one-cycle pulse when a partial frame is discarded
//
// FSM states:
//   state      | meaning
//   ST_IDLE    | empty frame, waiting for the first byte
//   ST_REQ     | partial frame, issue a read when the FIFO has data
//   ST_CAPTURE | rx_data valid this cycle, write it into the frame
//   ST_HOLD    | frame complete, wait for frame_ready
module uart_frame_assembler
  import uart_frame_pkg::*;
#(
  parameter int NUM_BYTES      = 28,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  input  logic               rx_empty,
  input  logic [7:0]         rx_data,
  output logic               rd_uart,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               busy,
  output logic [4:0]         byte_cnt,
  output logic               timeout_err
);

  state_t             state, state_nxt;
  logic               rd_req;
  logic               capture;
  logic               accept;
  logic               tmo_hit;
  logic [FRAME_W-1:0] frame_q;
  logic [4:0]         cnt_q;
  logic               valid_q;

  localparam logic [4:0] LAST_IDX = 5'(NUM_BYTES - 1);

  assign busy = (cnt_q != 5'd0) && !valid_q;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE, ST_REQ: begin
        // A timeout wins over a read issued in the same cycle so the
        // discarded frame cannot pick up a stray byte.
        if (tmo_hit) begin
          state_nxt = ST_IDLE;
        end else if (!rx_empty && !valid_q) begin
          rd_req    = 1'b1;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture   = 1'b1;
        state_nxt = (cnt_q == LAST_IDX) ? ST_HOLD : ST_REQ;
      end
      ST_HOLD: begin
        if (frame_ready && valid_q) begin
          accept    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The strobe is decoded from state and rx_empty; gating with reset_n keeps
  // it low while reset is held even if the FIFO reports data.
  assign rd_uart = rd_req & reset_n;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
      cnt_q   <= 5'd0;
      valid_q <= 1'b0;
    end else if (capture) begin
      // byte_cnt < NUM_BYTES here, so writes never reach the zero pad.
      frame_q[{cnt_q, 3'b000} +: 8] <= rx_data;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == LAST_IDX) valid_q <= 1'b1;
    end else if (accept || tmo_hit) begin
      frame_q <= '0;
      cnt_q   <= 5'd0;
      valid_q <= 1'b0;
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_err_q;

  // Counter is zero on the first idle cycle after a capture, so the discard
  // lands exactly TIMEOUT_CYCLES edges after the capturing edge.
  assign tmo_hit = busy && (state == ST_REQ) &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= tmo_hit;
      if (capture || tmo_hit || !busy) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // No idle counter: partial frames wait forever. The comparison is constant
  // false and only keeps TIMEOUT_CYCLES referenced in this build.
  assign tmo_hit     = (TIMEOUT_CYCLES < 0);
  assign timeout_err = 1'b0;
`endif

  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign byte_cnt    = cnt_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Testbench for uart_frame_assembler. A queue-based non-FWFT FIFO model feeds
// the DUT; expected frames are built from the list of bytes pushed.
module tb_uart_frame_assembler;

  localparam int NUM_BYTES      = 28;
  localparam int TIMEOUT_CYCLES = 100;
`ifdef UART_FRAME_TIMEOUT_EN
  localparam int STALL_CYCLES   = 90;
`else
  localparam int STALL_CYCLES   = 1000;
`endif

  logic         clk_100MHz  = 1'b0;
  logic         reset_n     = 1'b0;
  logic         rx_empty    = 1'b1;
  logic [7:0]   rx_data     = 8'h00;
  logic         frame_ready = 1'b0;
  logic         rd_uart;
  logic [255:0] frame_data;
  logic         frame_valid;
  logic         busy;
  logic [4:0]   byte_cnt;
  logic         timeout_err;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int cyc       = 0;
  int rd_valid_viol = 0;
  int rd_cyc_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] sent_q[$];
  logic do_pop;

  uart_frame_assembler #(
    .NUM_BYTES      (NUM_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .rd_uart     (rd_uart),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .byte_cnt    (byte_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc++;

  // Non-FWFT FIFO: a strobe seen at an edge presents the byte shortly after it.
  always @(posedge clk_100MHz) begin
    do_pop = rd_uart && reset_n;
    #1;
    if (do_pop && fifo_q.size() != 0) rx_data = fifo_q.pop_front();
    rx_empty = (fifo_q.size() == 0);
  end

  always @(negedge clk_100MHz) begin
    if (rd_uart) rd_cyc_q.push_back(cyc);
    if (rd_uart && frame_valid) rd_valid_viol++;
  end

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    sent_q.push_back(b);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)));
  endtask

  // Reference frame: next NUM_BYTES pushed bytes, first byte lowest, rest zero.
  function automatic logic [255:0] expect_frame();
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < NUM_BYTES; i++) f[8*i +: 8] = sent_q.pop_front();
    return f;
  endfunction

  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_100MHz);
      if (frame_valid) found = 1'b1;
    end
  endtask

  task automatic wait_cnt(input logic [4:0] n, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_100MHz);
      if (byte_cnt == n) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    frame_ready = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    check_cnt++; if (rd_uart !== 1'b0) $display("FAIL reset_rd_uart got=%b exp=0", rd_uart); else pass_cnt++;
    check_cnt++; if (frame_valid !== 1'b0) $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    check_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); else pass_cnt++;
    check_cnt++; if (byte_cnt !== 5'd0) $display("FAIL reset_byte_cnt got=%0d exp=0", byte_cnt); else pass_cnt++;
    check_cnt++; if (frame_data !== 256'd0) $display("FAIL reset_frame_data got=%h exp=0", frame_data); else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk_100MHz);
  endtask

  task automatic test_sequential();
    bit found;
    logic [255:0] exp;
    int first_rd, last_rd;
    frame_ready = 1'b1;
    rd_cyc_q.delete();
    for (int i = 0; i < NUM_BYTES; i++) push_byte(8'(i));
    wait_valid(200, found);
    check_cnt++; if (!found) $display("FAIL seq_valid_timeout got=0 exp=1"); else pass_cnt++;
    exp = expect_frame();
    first_rd = (rd_cyc_q.size() != 0) ? rd_cyc_q[0] : -1000;
    last_rd  = (rd_cyc_q.size() != 0) ? rd_cyc_q[$] : -1000;
    check_cnt++; if (rd_cyc_q.size() != NUM_BYTES) $display("FAIL seq_rd_count got=%0d exp=%0d", rd_cyc_q.size(), NUM_BYTES); else pass_cnt++;
    check_cnt++; if (cyc - last_rd != 2) $display("FAIL seq_latency got=%0d exp=2", cyc - last_rd); else pass_cnt++;
    check_cnt++; if (last_rd - first_rd != 2*(NUM_BYTES-1)) $display("FAIL seq_throughput got=%0d exp=%0d", last_rd - first_rd, 2*(NUM_BYTES-1)); else pass_cnt++;
    check_cnt++; if (frame_data !== exp) $display("FAIL seq_frame got=%h exp=%h", frame_data, exp); else pass_cnt++;
    check_cnt++; if (frame_data[7:0] !== 8'h00) $display("FAIL seq_first_byte got=%h exp=00", frame_data[7:0]); else pass_cnt++;
    check_cnt++; if (frame_data[223:216] !== 8'h1B) $display("FAIL seq_last_byte got=%h exp=1b", frame_data[223:216]); else pass_cnt++;
    check_cnt++; if (frame_data[255:224] !== 32'd0) $display("FAIL seq_pad got=%h exp=0", frame_data[255:224]); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL seq_busy_in_hold got=%b exp=0", busy); else pass_cnt++;
    @(negedge clk_100MHz);
    check_cnt++; if (frame_valid !== 1'b0) $display("FAIL seq_valid_drop got=%b exp=0", frame_valid); else pass_cnt++;
    check_cnt++; if (byte_cnt !== 5'd0 || frame_data !== 256'd0) $display("FAIL seq_clear got=%0d/%h exp=0/0", byte_cnt, frame_data); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit found;
    logic [255:0] exp;
    int rd0, viol0, mism;
    frame_ready = 1'b0;
    push_random(NUM_BYTES + 5);
    wait_valid(200, found);
    check_cnt++; if (!found) $display("FAIL bp_valid_timeout got=0 exp=1"); else pass_cnt++;
    exp = expect_frame();
    rd0 = rd_cyc_q.size();
    viol0 = rd_valid_viol;
    mism = 0;
    repeat (50) begin
      @(negedge clk_100MHz);
      if (frame_data !== exp || frame_valid !== 1'b1) mism++;
    end
    check_cnt++; if (mism != 0) $display("FAIL bp_stable got=%0d exp=0 unstable cycles", mism); else pass_cnt++;
    check_cnt++; if (rd_cyc_q.size() != rd0) $display("FAIL bp_no_read got=%0d exp=%0d", rd_cyc_q.size(), rd0); else pass_cnt++;
    check_cnt++; if (rd_valid_viol != viol0) $display("FAIL bp_rd_while_valid got=%0d exp=%0d", rd_valid_viol, viol0); else pass_cnt++;
    check_cnt++; if (fifo_q.size() != 5) $display("FAIL bp_fifo_level got=%0d exp=5", fifo_q.size()); else pass_cnt++;
    frame_ready = 1'b1;
    #1;
    check_cnt++; if (rd_uart !== 1'b0) $display("FAIL bp_no_prefetch got=%b exp=0", rd_uart); else pass_cnt++;
    @(negedge clk_100MHz);
    frame_ready = 1'b0;
    check_cnt++; if (frame_valid !== 1'b0) $display("FAIL bp_handshake_drop got=%b exp=0", frame_valid); else pass_cnt++;
    check_cnt++; if (rd_uart !== 1'b1) $display("FAIL bp_next_frame_start got=%b exp=1", rd_uart); else pass_cnt++;
    push_random(NUM_BYTES - 5);
    wait_valid(200, found);
    exp = expect_frame();
    check_cnt++; if (!found || frame_data !== exp) $display("FAIL bp_second_frame got=%h exp=%h", frame_data, exp); else pass_cnt++;
    frame_ready = 1'b1;
    @(negedge clk_100MHz);
  endtask

  task automatic test_stall();
    bit found;
    logic [255:0] exp;
    int bad;
    frame_ready = 1'b1;
    push_random(10);
    wait_cnt(5'd10, 100, found);
    check_cnt++; if (!found) $display("FAIL stall_first_part got=%0d exp=10", byte_cnt); else pass_cnt++;
    bad = 0;
    repeat (STALL_CYCLES) begin
      @(negedge clk_100MHz);
      if (busy !== 1'b1 || byte_cnt !== 5'd10 || rd_uart !== 1'b0) bad++;
    end
    check_cnt++; if (bad != 0) $display("FAIL stall_hold got=%0d exp=0 bad cycles", bad); else pass_cnt++;
    push_random(NUM_BYTES - 10);
    wait_valid(200, found);
    exp = expect_frame();
    check_cnt++; if (!found || frame_data !== exp) $display("FAIL stall_frame got=%h exp=%h", frame_data, exp); else pass_cnt++;
    @(negedge clk_100MHz);
  endtask

  task automatic test_reset_midframe();
    bit found;
    logic [255:0] exp;
    frame_ready = 1'b1;
    push_random(NUM_BYTES);
    wait_cnt(5'd15, 100, found);
    check_cnt++; if (!found) $display("FAIL rst_mid_reach got=%0d exp=15", byte_cnt); else pass_cnt++;
    reset_n = 1'b0;
    fifo_q.delete();
    sent_q.delete();
    #1;
    check_cnt++; if ({rd_uart, frame_valid, busy, timeout_err, byte_cnt} !== 9'd0)
      $display("FAIL rst_mid_ctrl got=%b%b%b%b/%0d exp=0000/0", rd_uart, frame_valid, busy, timeout_err, byte_cnt); else pass_cnt++;
    check_cnt++; if (frame_data !== 256'd0) $display("FAIL rst_mid_data got=%h exp=0", frame_data); else pass_cnt++;
    repeat (2) @(negedge clk_100MHz);
    reset_n = 1'b1;
    @(negedge clk_100MHz);
    check_cnt++; if (byte_cnt !== 5'd0) $display("FAIL rst_mid_after got=%0d exp=0", byte_cnt); else pass_cnt++;
    push_random(NUM_BYTES);
    wait_valid(200, found);
    exp = expect_frame();
    check_cnt++; if (!found || frame_data !== exp) $display("FAIL rst_mid_frame got=%h exp=%h", frame_data, exp); else pass_cnt++;
    @(negedge clk_100MHz);
  endtask

  task automatic test_timeout();
    bit found;
    logic [255:0] exp;
`ifdef UART_FRAME_TIMEOUT_EN
    bit seen;
    int err_cyc;
    logic [4:0] cnt_at;
`else
    int pulses;
`endif
    frame_ready = 1'b1;
    rd_cyc_q.delete();
    push_random(5);
    wait_cnt(5'd5, 50, found);
    check_cnt++; if (!found) $display("FAIL tmo_partial got=%0d exp=5", byte_cnt); else pass_cnt++;
`ifdef UART_FRAME_TIMEOUT_EN
    seen = 1'b0;
    err_cyc = 0;
    cnt_at = 5'h1F;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_100MHz);
      if (timeout_err) begin
        seen = 1'b1;
        err_cyc = cyc;
        cnt_at = byte_cnt;
      end
    end
    check_cnt++; if (!seen) $display("FAIL tmo_pulse got=0 exp=1"); else pass_cnt++;
    check_cnt++; if (err_cyc - rd_cyc_q[$] != TIMEOUT_CYCLES + 2)
      $display("FAIL tmo_delay got=%0d exp=%0d", err_cyc - rd_cyc_q[$], TIMEOUT_CYCLES + 2); else pass_cnt++;
    check_cnt++; if (cnt_at !== 5'd0) $display("FAIL tmo_discard got=%0d exp=0", cnt_at); else pass_cnt++;
    @(negedge clk_100MHz);
    check_cnt++; if (timeout_err !== 1'b0) $display("FAIL tmo_width got=%b exp=0", timeout_err); else pass_cnt++;
    sent_q.delete();
    push_random(NUM_BYTES);
`else
    pulses = 0;
    repeat (300) begin
      @(negedge clk_100MHz);
      if (timeout_err !== 1'b0) pulses++;
    end
    check_cnt++; if (pulses != 0) $display("FAIL tmo_never got=%0d exp=0", pulses); else pass_cnt++;
    check_cnt++; if (byte_cnt !== 5'd5 || busy !== 1'b1) $display("FAIL tmo_hold got=%0d/%b exp=5/1", byte_cnt, busy); else pass_cnt++;
    push_random(NUM_BYTES - 5);
`endif
    wait_valid(200, found);
    exp = expect_frame();
    check_cnt++; if (!found || frame_data !== exp) $display("FAIL tmo_next_frame got=%h exp=%h", frame_data, exp); else pass_cnt++;
    @(negedge clk_100MHz);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_stall();
    test_reset_midframe();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/uart_frame_assembler.md
UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 Parameter NUM_BYTES, default 28, SHALL set the bytes per frame: 12 key, 8 block A, 8 block B.
REQ-003 Parameter TIMEOUT_CYCLES, default 10_000_000, SHALL set the inter-byte idle limit in clk_100MHz cycles (100 ms).
REQ-004 Port clk_100MHz, input, 1 bit, SHALL be the system clock.
REQ-005 Port reset_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port rx_empty, input, 1 bit, SHALL be the rx FIFO empty flag.
REQ-007 Port rx_data, input, 8 bits, SHALL be the rx FIFO read data, valid in the cycle after the rd_uart pulse (non-FWFT).
REQ-008 Port rd_uart, output, 1 bit, SHALL be the rx FIFO read strobe, at most one cycle per byte.
REQ-009 Port frame_data, output, 256 bits, SHALL be the assembled frame: [95:0] key, [159:96] block A, [223:160] block B, [255:224] zero.
REQ-010 Port frame_valid, output, 1 bit, SHALL indicate that frame_data is complete and stable.
REQ-011 Port frame_ready, input, 1 bit, SHALL be the downstream accept signal.
REQ-012 Port busy, output, 1 bit, SHALL be high when a partial frame is held (byte_cnt > 0 and frame_valid low).
REQ-013 Port byte_cnt, output, 5 bits, SHALL be the number of bytes captured in the current frame.
REQ-014 Port timeout_err, output, 1 bit, SHALL be a one-cycle pulse when a partial frame is discarded (macro-dependent; see Configuration).

Function
REQ-015 The FSM SHALL have states IDLE, REQ, CAPTURE and HOLD.
REQ-016 IDLE/REQ: if rx_empty is low and frame_valid is low, the block SHALL assert rd_uart for one cycle and move to CAPTURE; otherwise it SHALL wait with rd_uart low.
REQ-017 CAPTURE: the block SHALL write rx_data into frame_data[8*byte_cnt+7 : 8*byte_cnt] and increment byte_cnt (first byte lands in [7:0]).
REQ-018 CAPTURE: if the incremented byte_cnt equals NUM_BYTES, the FSM SHALL go to HOLD and raise frame_valid in the next cycle; otherwise it SHALL go to REQ.
REQ-019 Peak throughput SHALL be one byte per 2 cycles; latency from the last byte's rd_uart to frame_valid SHALL be 2 cycles.
REQ-020 HOLD: frame_valid and frame_data SHALL stay stable and no rd_uart SHALL issue until frame_ready is high.
REQ-021 Valid&ready: on the handshake cycle the block SHALL clear frame_valid, clear byte_cnt and frame_data, and return to IDLE; it SHALL NOT prefetch in that cycle.
REQ-022 frame_ready while frame_valid is low SHALL be ignored.
REQ-023 The rx FIFO going empty mid-frame SHALL stall in REQ with the captured bytes retained.
REQ-024 byte_cnt SHALL never exceed NUM_BYTES and SHALL never wrap.

Reset
REQ-025 Asserting reset_n low at any time, including mid-frame or in HOLD, SHALL force IDLE.
REQ-026 Reset SHALL clear rd_uart, frame_valid, busy and timeout_err to 0, byte_cnt to 0, frame_data to all zeros, and the timeout counter to 0.
REQ-027 A byte whose read is in flight when reset asserts SHALL be dropped.

Configuration
REQ-028 With macro UART_FRAME_TIMEOUT_EN defined, a cycle counter SHALL run whenever busy is high and SHALL reset on every CAPTURE.
REQ-029 When that counter reaches TIMEOUT_CYCLES, the block SHALL discard the partial frame (byte_cnt and frame_data cleared), pulse timeout_err for one cycle, and return to IDLE.
REQ-030 Without UART_FRAME_TIMEOUT_EN, no counter SHALL be instantiated, timeout_err SHALL be tied to 0, and partial frames SHALL wait indefinitely.

Structure
REQ-031 A shared package uart_frame_pkg SHALL hold the state enum, the FRAME_W=256 constant, and the field offsets KEY_LSB=0, BLKA_LSB=96 and BLKB_LSB=160.
REQ-032 No sub-module SHALL be instantiated; the timeout counter SHALL remain inline under the macro.

Verification
REQ-033 Push 28 bytes 0x00..0x1B with frame_ready high -> frame_valid rises 2 cycles after the 28th rd_uart, frame_data[7:0]=0x00 and [223:216]=0x1B, [255:224]=0, and frame_valid drops the next cycle.
REQ-034 Complete a frame with frame_ready low for 50 cycles while 5 more bytes sit in the FIFO -> no rd_uart while frame_valid is high, data stays stable, and the next frame begins after the handshake.
REQ-035 Push 10 bytes, hold rx_empty high for 1000 cycles, then push 18 bytes -> busy stays high with byte_cnt=10 during the gap, and the frame completes correctly.
REQ-036 Assert reset_n low after 15 bytes -> all outputs return to their reset values, then 28 new bytes form a correct frame.
REQ-037 With UART_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=100, push 5 bytes then idle -> a one-cycle timeout_err pulse occurs 100 cycles after the last capture, byte_cnt=0, and the next 28 bytes frame correctly.
REQ-038 Without UART_FRAME_TIMEOUT_EN, repeat REQ-037 -> timeout_err never pulses and byte_cnt holds at 5.
